bist_unit: RTL and testbench

//  Computes out = a * floor(sqrt(b)) on 8-bit operands in functional mode.
//  A built-in self-test (BIST) mode drives the same datapath with LFSR patterns.
//  In BIST mode the results are compacted into a CRC-8 signature.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_unit_if.sv | 10 +
 rtl/bist_unit_sqrt_mul_core.sv | 88 ++++++++
 rtl/bist_unit.sv | 113 +++++++++++
 tb/tb_bist_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types, constants and CRC/LFSR helpers for the self-testing a*isqrt(b) unit.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, SQRT, MUL, DONE} state_t;
    typedef enum logic [1:0] {FUNC, BIST_RUN, BIST_DONE} mode_t;

    localparam logic [7:0]  CRC8_POLY = 8'h07;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // CRC-8, MSB first, no reflection, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

endpackage

// File: rtl/bist_unit_if.sv
// Operand/result bundle of bist_unit; the driver side is master, the unit is slave.
interface bist_unit_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        test;
    logic [15:0] out;

    modport master (output a, b, test, input out);
    modport slave  (input a, b, test, output out);
endinterface

// File: rtl/bist_unit_sqrt_mul_core.sv
// Iterative datapath: 4-step restoring isqrt of b, then 4-step shift-add a*root.
module sqrt_mul_core
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        done,
    output logic [11:0] result
);

    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic [7:0]  b_r;
    logic [9:0]  rem;
    logic [3:0]  root;
    logic [11:0] mcand;
    logic [11:0] acc;
    logic [9:0]  rem_sh;
    logic [9:0]  trial;
    logic        ge;

    assign rem_sh = {rem[7:0], b_r[7:6]};
    assign trial  = {4'b0, root, 2'b01};
    assign ge     = rem_sh >= trial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SQRT;
            SQRT:    if (cnt == 2'd3) state_nx = MUL;
            MUL:     if (cnt == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            b_r   <= '0;
            rem   <= '0;
            root  <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    b_r   <= b;
                    mcand <= {4'b0, a};
                    rem   <= '0;
                    root  <= '0;
                    acc   <= '0;
                    cnt   <= '0;
                end
                SQRT: begin
                    b_r  <= b_r << 2;
                    rem  <= ge ? (rem_sh - trial) : rem_sh;
                    root <= {root[2:0], ge};
                    cnt  <= cnt + 2'd1;
                end
                // root is consumed LSB first as the multiplier
                MUL: begin
                    if (root[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    root  <= root >> 1;
                    cnt   <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign done   = (state == DONE);
    assign result = acc;

endmodule

// File: rtl/bist_unit.sv
// out = a*isqrt(b) in functional mode; LFSR-driven BIST compacted into a CRC-8 signature.
// Optional BIST_ABORT_EN: a test edge during a running session aborts it back to FUNC.
module bist_unit
    import bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 255,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [7:0]  CRC_INIT   = 8'h00
)(
    input  logic        clk,
    input  logic        rst,
    bist_unit_if.slave  bus
);

    mode_t       mode, mode_nx;
    logic        test_q, test_rise;
    logic [15:0] lfsr;
    logic [7:0]  crc, crc_nx;
    logic [15:0] pat_cnt;
    logic [7:0]  test_cnt;
    logic [15:0] out_r;
    logic        core_start, core_clear, core_done, start_bist, take, last;
    logic [7:0]  core_a, core_b;
    logic [11:0] core_res;
    logic [15:0] res16;

    sqrt_mul_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clear  (core_clear),
        .start  (core_start),
        .a      (core_a),
        .b      (core_b),
        .done   (core_done),
        .result (core_res)
    );

    assign test_rise = bus.test & ~test_q;
    assign res16     = {4'b0, core_res};
    assign crc_nx    = crc8_byte(crc8_byte(crc, res16[15:8]), res16[7:0]);
    assign last      = (pat_cnt == 16'(N_PATTERNS - 1));
    assign take      = core_done & ~core_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode <= FUNC;
        else      mode <= mode_nx;
    end

    always_comb begin
        mode_nx    = mode;
        core_start = 1'b0;
        core_clear = 1'b0;
        start_bist = 1'b0;
        core_a     = bus.a;
        core_b     = bus.b;
        case (mode)
            FUNC: begin
                core_start = 1'b1;
                if (test_rise) begin
                    mode_nx    = BIST_RUN;
                    core_clear = 1'b1;
                    start_bist = 1'b1;
                end
            end
            BIST_RUN: begin
                core_start = 1'b1;
                core_a     = lfsr[15:8];
                core_b     = lfsr[7:0];
                if (core_done && last) mode_nx = BIST_DONE;
`ifdef BIST_ABORT_EN
                if (test_rise) begin
                    mode_nx    = FUNC;
                    core_clear = 1'b1;
                end
`endif
            end
            BIST_DONE: if (test_rise) mode_nx = FUNC;
            default:   mode_nx = FUNC;
        endcase
    end

    // LFSR advances on each pattern's completion, after its operands were latched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_q   <= 1'b0;
            lfsr     <= LFSR_SEED;
            crc      <= CRC_INIT;
            pat_cnt  <= '0;
            test_cnt <= '0;
            out_r    <= '0;
        end else begin
            test_q <= bus.test;
            if (start_bist) begin
                lfsr    <= LFSR_SEED;
                crc     <= CRC_INIT;
                pat_cnt <= '0;
            end else if (mode == BIST_RUN && take) begin
                lfsr    <= lfsr_step(lfsr);
                crc     <= crc_nx;
                pat_cnt <= pat_cnt + 16'd1;
                if (last) begin
                    test_cnt <= test_cnt + 8'd1;
                    out_r    <= {test_cnt + 8'd1, crc_nx};
                end
            end else if (mode == FUNC && take) begin
                out_r <= res16;
            end
        end
    end

    assign bus.out = out_r;

endmodule

// File: tb/tb_bist_unit.sv
// Scoreboard bench for bist_unit: stimulus queues expectations, a monitor polls out against them.
module tb_bist_unit;

    localparam int unsigned NP    = 255;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [7:0]  CINIT = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bist_unit_if bus ();

    bist_unit #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .CRC_INIT(CINIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] exp;
        int unsigned budget;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic int unsigned isqrt_ref(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic logic [15:0] func_ref(input logic [7:0] a, input logic [7:0] b);
        return 16'(int'(a) * isqrt_ref(int'(b)));
    endfunction

    // Signature computed bitwise over the 16-bit result stream
    function automatic logic [7:0] bist_crc_ref();
        logic [15:0] l;
        logic [7:0]  c;
        logic [15:0] res;
        logic        fb;
        l = SEED;
        c = CINIT;
        for (int unsigned p = 0; p < NP; p++) begin
            res = func_ref(l[15:8], l[7:0]);
            for (int k = 15; k >= 0; k--) begin
                fb = c[7] ^ res[k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        return c;
    endfunction

    initial begin : monitor
        item_t       it;
        int unsigned n;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            it = sb[0];
            #1;
            n = 0;
            while (bus.out !== it.exp && n < it.budget) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.out !== it.exp) begin
                errors++;
                $display("FAIL %s: out=%h expected=%h", it.name, bus.out, it.exp);
            end
            void'(sb.pop_front());
        end
    end

    task automatic push(input string name, input logic [15:0] exp, input int unsigned budget);
        item_t it;
        it.name   = name;
        it.exp    = exp;
        it.budget = budget;
        sb.push_back(it);
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
    endtask

    task automatic pulse(input int unsigned n);
        bus.test = 1'b1;
        repeat (n) @(negedge clk);
        bus.test = 1'b0;
    endtask

    task automatic func_check(input string name, input logic [7:0] a, input logic [7:0] b);
        bus.a = a;
        bus.b = b;
        push(name, func_ref(a, b), 25);
        drain(40);
    endtask

    logic [7:0]  crc;
    logic [7:0]  ra, rb;

    initial begin
        bus.a    = 8'h00;
        bus.b    = 8'h00;
        bus.test = 1'b0;
        crc      = bist_crc_ref();

        repeat (2) @(negedge clk);
        push("reset out", 16'h0000, 0);
        drain(10);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        push("zero operands", 16'h0000, 0);
        drain(10);

        func_check("func 45*isqrt(2a)", 8'h45, 8'h2a);
        func_check("func 8e*isqrt(c2)", 8'h8e, 8'hc2);
        func_check("func ff*isqrt(ff)", 8'hff, 8'hff);
        func_check("func b=0", 8'h77, 8'h00);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            func_check($sformatf("func rand %h*isqrt(%h)", ra, rb), ra, rb);
        end

        pulse(17);
        push("bist session 1", {8'd1, crc}, 3000);
        drain(3100);
        repeat (30) @(negedge clk);
        push("bist done hold", {8'd1, crc}, 0);
        drain(10);

        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        bus.a = ra;
        bus.b = rb;
        pulse(3);
        push("return to func", func_ref(ra, rb), 25);
        drain(40);

        pulse(17);
        repeat (800) @(negedge clk);
        push("out held in bist", func_ref(ra, rb), 0);
        drain(10);
        pulse(5);
        push("bist session 2", {8'd2, crc}, 3000);
        drain(3100);

        pulse(3);
        push("return to func 2", func_ref(ra, rb), 25);
        drain(40);

        pulse(17);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        push("async reset mid-bist", 16'h0000, 0);
        drain(5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        func_check("func after reset", 8'h5c, 8'h91);
        pulse(17);
        push("bist after reset", {8'd1, crc}, 3000);
        drain(3100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
